vc_allocator: RTL and testbench

Virtual-channel allocator for the NoC router. Head flits buffered in input virtual channels request a downstream VC on the output port chosen by route computation. The block arbitrates round-robin among all requesting input VCs per output port, assigns a free downstream VC, and tracks downstream VC occupancy until the tail is released. It sits between route computation and the switch allocator (`in_out_allocator`). An input VC may request switch allocation only after holding a VC grant.

---
 rtl/params_noc.sv | 16 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/vc_allocator.sv | 114 +++++++++++
 tb/tb_vc_allocator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_noc.sv
// Shared NoC router parameters: port count and the output-port encoding
// produced by route computation.
package params_noc;

    localparam int in_Port_Cnt = 5;
    localparam int PORT_W      = 3;

    typedef enum logic [PORT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } inout_Port;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps,
// so the previous winner has the lowest priority.
module rr_arbiter #(
    parameter int N     = 20,
    parameter int PTR_W = 5
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             valid
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % N);
            if (!valid && req[w_idx]) begin
                valid        = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

endmodule

// File: rtl/vc_allocator.sv
// Virtual-channel allocator: per output port, picks one requesting input VC
// round-robin and hands it the lowest free downstream VC on that port.
module vc_allocator
    import params_noc::*;
#(
    parameter int  vc_Num = 4,
    localparam int VC_PTR = (vc_Num > 1) ? $clog2(vc_Num) : 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic      [in_Port_Cnt-1:0][vc_Num-1:0]             va_req_i,
    input  inout_Port [in_Port_Cnt-1:0][vc_Num-1:0]             va_port_i,
    input  logic      [in_Port_Cnt-1:0][vc_Num-1:0]             release_i,
    output logic      [in_Port_Cnt-1:0][vc_Num-1:0]             va_grant_o,
    output logic      [in_Port_Cnt-1:0][vc_Num-1:0][VC_PTR-1:0] va_vc_o,
    output logic      [in_Port_Cnt-1:0][vc_Num-1:0]             vc_busy_o
);

    localparam int NREQ   = in_Port_Cnt * vc_Num;
    localparam int FLAT_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [in_Port_Cnt-1:0][vc_Num-1:0]             r_grant;
    logic [in_Port_Cnt-1:0][vc_Num-1:0][VC_PTR-1:0] r_vc;
    logic [in_Port_Cnt-1:0][vc_Num-1:0]             r_busy;
    logic [in_Port_Cnt-1:0][FLAT_W-1:0]             r_ptr;

    logic [in_Port_Cnt-1:0][NREQ-1:0]               w_req;
    logic [in_Port_Cnt-1:0][NREQ-1:0]               w_gnt;
    logic [in_Port_Cnt-1:0][FLAT_W-1:0]             w_gnt_idx;
    logic [in_Port_Cnt-1:0]                         w_valid;
    logic [in_Port_Cnt-1:0]                         w_free_any;
    logic [in_Port_Cnt-1:0][VC_PTR-1:0]             w_free_idx;
    logic [in_Port_Cnt-1:0]                         w_fire;
    logic [in_Port_Cnt-1:0][vc_Num-1:0]             w_busy_next;
    logic [in_Port_Cnt-1:0][vc_Num-1:0]             w_grant_next;
    logic [in_Port_Cnt-1:0][vc_Num-1:0][VC_PTR-1:0] w_vc_next;

    // A VC whose grant is on the outputs this cycle is masked so a held
    // request cannot win a second downstream VC.
    for (genvar gi = 0; gi < in_Port_Cnt; gi++) begin : g_port
        for (genvar gj = 0; gj < in_Port_Cnt; gj++) begin : g_in
            for (genvar gk = 0; gk < vc_Num; gk++) begin : g_vc
                assign w_req[gi][gj*vc_Num+gk] = va_req_i[gj][gk] && !r_grant[gj][gk]
                                              && (va_port_i[gj][gk] == inout_Port'(PORT_W'(gi)));
            end
        end

        rr_arbiter #(
            .N     (NREQ),
            .PTR_W (FLAT_W)
        ) u_arb (
            .req     (w_req[gi]),
            .ptr     (r_ptr[gi]),
            .gnt     (w_gnt[gi]),
            .gnt_idx (w_gnt_idx[gi]),
            .valid   (w_valid[gi])
        );
    end

    always_comb begin
        w_free_any   = '0;
        w_free_idx   = '0;
        w_fire       = '0;
        w_busy_next  = r_busy & ~release_i;
        w_grant_next = '0;
        w_vc_next    = '0;
        for (int p = 0; p < in_Port_Cnt; p++) begin
            for (int d = vc_Num - 1; d >= 0; d--) begin
                if (!r_busy[p][d]) begin
                    w_free_any[p] = 1'b1;
                    w_free_idx[p] = VC_PTR'(d);
                end
            end
            w_fire[p] = w_valid[p] && w_free_any[p];
            // Applied after the release mask so a same-cycle set wins.
            if (w_fire[p]) begin
                w_busy_next[p][w_free_idx[p]] = 1'b1;
            end
        end
        for (int i = 0; i < in_Port_Cnt; i++) begin
            for (int v = 0; v < vc_Num; v++) begin
                for (int p = 0; p < in_Port_Cnt; p++) begin
                    if (w_fire[p] && w_gnt[p][i*vc_Num+v]) begin
                        w_grant_next[i][v] = 1'b1;
                        w_vc_next[i][v]    = w_free_idx[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_vc    <= '0;
            r_busy  <= '0;
            r_ptr   <= {in_Port_Cnt{FLAT_W'(NREQ - 1)}};
        end else begin
            r_grant <= w_grant_next;
            r_vc    <= w_vc_next;
            r_busy  <= w_busy_next;
            for (int p = 0; p < in_Port_Cnt; p++) begin
                if (w_fire[p]) begin
                    r_ptr[p] <= w_gnt_idx[p];
                end
            end
        end
    end

    assign va_grant_o = r_grant;
    assign va_vc_o    = r_vc;
    assign vc_busy_o  = r_busy;

endmodule

// File: tb/tb_vc_allocator.sv
// Bench for vc_allocator: directed scenarios and random traffic, every edge
// checked against an array-based reference of the allocation rules.
module tb_vc_allocator;
    import params_noc::*;

    localparam int VCN = 4;
    localparam int NP  = in_Port_Cnt;
    localparam int NF  = NP * VCN;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic      [NP-1:0][VCN-1:0]      va_req  = '0;
    inout_Port [NP-1:0][VCN-1:0]      va_port = '{default: LOCAL};
    logic      [NP-1:0][VCN-1:0]      rel     = '0;
    logic      [NP-1:0][VCN-1:0]      va_grant_o;
    logic      [NP-1:0][VCN-1:0][1:0] va_vc_o;
    logic      [NP-1:0][VCN-1:0]      vc_busy_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: occupancy table, last winner per port, visible grants.
    int m_busy [NP][VCN];
    int m_ptr  [NP];
    int m_grant[NF];
    int m_vc   [NF];
    int m_prev [NF];

    vc_allocator #(.vc_Num(VCN)) dut (
        .clk        (clk),
        .rst        (rst),
        .va_req_i   (va_req),
        .va_port_i  (va_port),
        .release_i  (rel),
        .va_grant_o (va_grant_o),
        .va_vc_o    (va_vc_o),
        .vc_busy_o  (vc_busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int f, input inout_Port p);
        va_req[f / VCN][f % VCN]  = 1'b1;
        va_port[f / VCN][f % VCN] = p;
    endtask

    // Outcome of one rising edge given the inputs currently applied.
    task automatic model_edge();
        int ng[NF];
        int nv[NF];
        int setd[NP];
        int free_vc;
        int win;
        int f;
        for (int k = 0; k < NF; k++) begin
            ng[k] = 0;
            nv[k] = 0;
        end
        for (int p = 0; p < NP; p++) begin
            free_vc = -1;
            win     = -1;
            setd[p] = -1;
            for (int d = 0; d < VCN; d++)
                if (free_vc < 0 && m_busy[p][d] == 0) free_vc = d;
            for (int k = 1; k <= NF; k++) begin
                f = (m_ptr[p] + k) % NF;
                if (win < 0 && va_req[f / VCN][f % VCN] && int'(va_port[f / VCN][f % VCN]) == p
                    && m_grant[f] == 0) win = f;
            end
            if (win >= 0 && free_vc >= 0) begin
                ng[win]  = 1;
                nv[win]  = free_vc;
                setd[p]  = free_vc;
                m_ptr[p] = win;
            end
        end
        for (int p = 0; p < NP; p++)
            for (int d = 0; d < VCN; d++)
                if (rel[p][d]) m_busy[p][d] = 0;
        for (int p = 0; p < NP; p++)
            if (setd[p] >= 0) m_busy[p][setd[p]] = 1;
        for (int k = 0; k < NF; k++) begin
            m_grant[k] = ng[k];
            m_vc[k]    = nv[k];
        end
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                m_ptr[p] = NF - 1;
                for (int d = 0; d < VCN; d++) m_busy[p][d] = 0;
            end
            for (int k = 0; k < NF; k++) begin
                m_grant[k] = 0;
                m_vc[k]    = 0;
            end
        end
    endtask

    // One clock: predict, clock, compare, then requesters drop a request one
    // cycle after its grant was seen.
    task automatic cycle();
        logic [NF-1:0]      eg;
        logic [NF-1:0]      eb;
        logic [NF-1:0][1:0] ev;
        logic [NF-1:0][1:0] ov;
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < NF; k++) begin
            eg[k] = (m_grant[k] != 0);
            ev[k] = (m_grant[k] != 0) ? 2'(m_vc[k]) : 2'd0;
            ov[k] = (m_grant[k] != 0) ? va_vc_o[k / VCN][k % VCN] : 2'd0;
        end
        for (int p = 0; p < NP; p++)
            for (int d = 0; d < VCN; d++) eb[p*VCN+d] = (m_busy[p][d] != 0);
        chk("model_grant", va_grant_o, eg);
        chk("model_vc", ov, ev);
        chk("model_busy", vc_busy_o, eb);
        for (int k = 0; k < NF; k++) begin
            if (m_prev[k] != 0) va_req[k / VCN][k % VCN] = 1'b0;
            m_prev[k] = m_grant[k];
        end
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        va_req = '0;
        rel    = '0;
        cycle();
        rst = 1'b0;
    endtask

    logic [NF-1:0] exp_bits;

    initial begin
        for (int k = 0; k < NF; k++) begin
            m_grant[k] = 0;
            m_vc[k]    = 0;
            m_prev[k]  = 0;
        end

        // Reset values
        apply_reset();
        chk("rst_grant", va_grant_o, 64'd0);
        chk("rst_vc", va_vc_o, 64'd0);
        chk("rst_busy", vc_busy_o, 64'd0);

        // Single request: SOUTH input VC2 (flat 14) to EAST
        set_req(14, EAST);
        cycle();
        chk("single_grant", va_grant_o[3][2], 64'd1);
        chk("single_vc", va_vc_o[3][2], 64'd0);
        chk("single_busy", vc_busy_o[EAST], 64'b0001);
        cycle();
        chk("single_held_no_regrant", va_grant_o, 64'd0);
        cycle();
        chk("single_dropped", va_grant_o, 64'd0);

        // Contention on NORTH
        apply_reset();
        for (int f = 0; f < NF; f++) set_req(f, NORTH);
        for (int k = 0; k < 4; k++) begin
            cycle();
            exp_bits = NF'(1) << k;
            chk("contend_order", va_grant_o, exp_bits);
        end
        cycle();
        chk("contend_full", va_grant_o, 64'd0);
        rel[NORTH][1] = 1'b1;
        cycle();
        rel = '0;
        chk("contend_rel_nogrant", va_grant_o, 64'd0);
        chk("contend_rel_busy", vc_busy_o[NORTH], 64'b1101);
        cycle();
        exp_bits = NF'(1) << 4;
        chk("contend_after_rel", va_grant_o, exp_bits);
        chk("contend_after_rel_vc", va_vc_o[1][0], 64'd1);

        // Parallel ports: input i VC0 requests port i
        apply_reset();
        for (int i = 0; i < NP; i++) set_req(i * VCN, inout_Port'(3'(i)));
        cycle();
        chk("parallel_grants", va_grant_o, 64'h11111);
        for (int i = 0; i < NP; i++) chk("parallel_vc", va_vc_o[i][0], 64'd0);

        // Round-robin wrap on WEST
        apply_reset();
        set_req(19, WEST);
        cycle();
        chk("wrap_first", va_grant_o[4][3], 64'd1);
        cycle();
        cycle();
        set_req(3, WEST);
        set_req(18, WEST);
        cycle();
        chk("wrap_winner", va_grant_o, 64'h8);
        chk("wrap_winner_vc", va_vc_o[0][3], 64'd1);
        cycle();
        exp_bits = NF'(1) << 18;
        chk("wrap_second", va_grant_o, exp_bits);

        // Release/allocate boundary on LOCAL
        apply_reset();
        for (int f = 0; f < 4; f++) set_req(f, LOCAL);
        repeat (4) cycle();
        set_req(5, LOCAL);
        cycle();
        cycle();
        chk("bound_full_busy", vc_busy_o[LOCAL], 64'hF);
        chk("bound_full_nogrant", va_grant_o, 64'd0);
        rel[LOCAL][3] = 1'b1;
        cycle();
        rel = '0;
        chk("bound_rel_edge_nogrant", va_grant_o, 64'd0);
        chk("bound_rel_busy", vc_busy_o[LOCAL], 64'h7);
        cycle();
        chk("bound_grant", va_grant_o, 64'h20);
        chk("bound_grant_vc", va_vc_o[1][1], 64'd3);
        rel[EAST][2] = 1'b1;
        cycle();
        rel = '0;
        chk("bound_free_release", vc_busy_o, 64'h0000F);

        // Reset mid-operation
        apply_reset();
        set_req(8, NORTH);
        set_req(9, NORTH);
        set_req(10, NORTH);
        repeat (3) cycle();
        chk("midrst_busy", vc_busy_o[NORTH], 64'h7);
        chk("midrst_pending", va_grant_o[2][2], 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_grant", va_grant_o, 64'd0);
        chk("midrst_vc", va_vc_o, 64'd0);
        chk("midrst_busy_clr", vc_busy_o, 64'd0);
        va_req = '0;
        set_req(12, NORTH);
        set_req(7, NORTH);
        cycle();
        chk("midrst_prio", va_grant_o, 64'h80);
        chk("midrst_vc0", va_vc_o[1][3], 64'd0);

        // Random traffic
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            for (int f = 0; f < NF; f++)
                if (!va_req[f / VCN][f % VCN] && $urandom_range(0, 3) == 0)
                    set_req(f, inout_Port'(3'($urandom_range(0, NP - 1))));
            for (int p = 0; p < NP; p++)
                for (int d = 0; d < VCN; d++) rel[p][d] = ($urandom_range(0, 7) == 0);
            rst = (n == 200);
            cycle();
            rel = '0;
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
